// File: rtl/ram_load_sequencer.sv
// Loads the data, weight and bias BRAMs from one host pipe stream by packing 16-bit words into BURST_LEN-lane lines.
// Latency: a line's write strobe follows the handshake that completes it by 1 cycle; done follows the last word by 2 cycles.
// Backpressure: in_ready is high only while packing, holds through write-strobe cycles, and drops after the last word.
// Ports: clk/rst; start/sel/base_addr/word_count program a transfer; in_valid/in_data/in_ready carry the pipe stream;
//        d_/w_/b_ we+addr drive the three BRAM A-ports with shared wdata; busy/done/err report status.
module ram_load_sequencer #(
  parameter int BURST_LEN = 8,
  parameter int D_AW      = 10,
  parameter int W_AW      = 13,
  parameter int B_AW      = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [1:0]             sel,
  input  logic [12:0]            base_addr,
  input  logic [15:0]            word_count,
  input  logic                   in_valid,
  input  logic [31:0]            in_data,
  output logic                   in_ready,
  output logic                   d_we,
  output logic                   w_we,
  output logic                   b_we,
  output logic [D_AW-1:0]        d_addr,
  output logic [W_AW-1:0]        w_addr,
  output logic [B_AW-1:0]        b_addr,
  output logic [16*BURST_LEN-1:0] wdata,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int LINE_W = 16 * BURST_LEN;
  localparam int LCW    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  typedef enum logic [1:0] {IDLE, PACK, DONE} state_t;

  state_t            state;
  logic [1:0]        sel_r;
  logic [12:0]       base_r;
  logic [15:0]       remaining;
  logic [LCW-1:0]    lane_cnt;
  logic [13:0]       line_idx;   // up to ceil(65535/8) lines
  logic [LINE_W-1:0] line_buf;
  logic [LINE_W-1:0] line_next;
  logic              hs;
  logic              last_word;
  logic              emit;
  logic              wrap;
  logic [14:0]       d_sum;
  logic [14:0]       w_sum;
  logic [14:0]       b_sum;
  logic              unused_hi;

  // Upper half of each pipe word carries nothing for this block.
  assign unused_hi = ^in_data[31:16];

  always_comb begin
    hs        = in_valid & in_ready;
    last_word = (remaining == 16'd1);
    emit      = hs & (last_word | (lane_cnt == LCW'(BURST_LEN - 1)));
    line_next = line_buf;
    line_next[16*int'(lane_cnt) +: 16] = in_data[15:0];
    // Sums are computed wide so a carry out of the target's AW flags wrap.
    d_sum = 15'(base_r[D_AW-1:0]) + 15'(line_idx);
    w_sum = 15'(base_r[W_AW-1:0]) + 15'(line_idx);
    b_sum = 15'(base_r[B_AW-1:0]) + 15'(line_idx);
    case (sel_r)
      2'd0:    wrap = (d_sum >> D_AW) != 15'd0;
      2'd1:    wrap = (w_sum >> W_AW) != 15'd0;
      2'd2:    wrap = (b_sum >> B_AW) != 15'd0;
      default: wrap = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sel_r     <= 2'd0;
      base_r    <= 13'd0;
      remaining <= 16'd0;
      lane_cnt  <= '0;
      line_idx  <= 14'd0;
      line_buf  <= '0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      d_we      <= 1'b0;
      w_we      <= 1'b0;
      b_we      <= 1'b0;
      d_addr    <= '0;
      w_addr    <= '0;
      b_addr    <= '0;
      wdata     <= '0;
    end else begin
      d_we <= 1'b0;
      w_we <= 1'b0;
      b_we <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sel_r     <= sel;
            base_r    <= base_addr;
            remaining <= word_count;
            lane_cnt  <= '0;
            line_idx  <= 14'd0;
            line_buf  <= '0;
            busy      <= 1'b1;
            err       <= (sel == 2'd3);
            if (word_count == 16'd0 || sel == 2'd3) begin
              state <= DONE;
            end else begin
              state    <= PACK;
              in_ready <= 1'b1;
            end
          end
        end
        PACK: begin
          if (hs) begin
            remaining <= remaining - 16'd1;
            if (emit) begin
              wdata    <= line_next;
              line_buf <= '0;
              lane_cnt <= '0;
              line_idx <= line_idx + 14'd1;
              if (wrap) err <= 1'b1;
              case (sel_r)
                2'd0: begin d_we <= 1'b1; d_addr <= d_sum[D_AW-1:0]; end
                2'd1: begin w_we <= 1'b1; w_addr <= w_sum[W_AW-1:0]; end
                2'd2: begin b_we <= 1'b1; b_addr <= b_sum[B_AW-1:0]; end
                default: ;
              endcase
            end else begin
              line_buf <= line_next;
              lane_cnt <= lane_cnt + LCW'(1);
            end
            if (last_word) begin
              in_ready <= 1'b0;
              state    <= DONE;
            end
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_load_sequencer.sv
module tb_ram_load_sequencer;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   sel;
  logic [12:0]  base_addr;
  logic [15:0]  word_count;
  logic         in_valid;
  logic [31:0]  in_data;
  logic         in_ready;
  logic         d_we, w_we, b_we;
  logic [9:0]   d_addr;
  logic [12:0]  w_addr;
  logic [9:0]   b_addr;
  logic [127:0] wdata;
  logic         busy, done, err;

  int errors = 0;
  int checks = 0;

  logic [1:0]   wr_ram[$];
  logic [12:0]  wr_addr[$];
  logic [127:0] wr_dat[$];
  int           done_cnt = 0;

  ram_load_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .sel(sel), .base_addr(base_addr),
    .word_count(word_count), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .d_we(d_we), .w_we(w_we), .b_we(b_we), .d_addr(d_addr), .w_addr(w_addr), .b_addr(b_addr),
    .wdata(wdata), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Log every write strobe and done pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (d_we) begin wr_ram.push_back(2'd0); wr_addr.push_back(13'(d_addr)); wr_dat.push_back(wdata); end
    if (w_we) begin wr_ram.push_back(2'd1); wr_addr.push_back(w_addr);       wr_dat.push_back(wdata); end
    if (b_we) begin wr_ram.push_back(2'd2); wr_addr.push_back(13'(b_addr)); wr_dat.push_back(wdata); end
    if (done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected line: lanes 0..nvalid-1 hold v0, v0+1, ...; upper lanes zero.
  function automatic logic [127:0] mk_line(input logic [15:0] v0, input int nvalid);
    logic [127:0] l = '0;
    for (int i = 0; i < nvalid; i++) l[16*i +: 16] = v0 + 16'(i);
    return l;
  endfunction

  task automatic do_start(input logic [1:0] s, input logic [12:0] b, input logic [15:0] c);
    start = 1'b1; sel = s; base_addr = b; word_count = c;
    tick();
    start = 1'b0;
  endtask

  // Feeds n words v0+k; returns words accepted and cycles spent. Returns right after
  // the edge that accepted the last word.
  task automatic stream(input int n, input logic [15:0] v0, input bit rnd,
                        output int got, output int cyc);
    logic hs;
    got = 0; cyc = 0;
    while (got < n && cyc < 2000) begin
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = {16'hA5A5, v0 + 16'(got)};
      hs = in_valid && in_ready;
      tick();
      cyc++;
      if (hs) got++;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++; if ({in_ready, busy, done, err} !== 4'b0000) begin errors++; $display("FAIL reset_status: got %b exp 0000", {in_ready, busy, done, err}); end
    checks++; if ({d_we, w_we, b_we} !== 3'b000) begin errors++; $display("FAIL reset_we: got %b exp 000", {d_we, w_we, b_we}); end
    checks++; if ({d_addr, w_addr, b_addr} !== 33'd0 || wdata !== 128'd0) begin errors++; $display("FAIL reset_addr_data: got %h/%h exp 0", {d_addr, w_addr, b_addr}, wdata); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_full_line();
    int n0 = wr_ram.size();
    int got, cyc;
    do_start(2'd0, 13'd0, 16'd8);
    checks++; if ({busy, in_ready} !== 2'b11) begin errors++; $display("FAIL t1_start_busy_rdy: got %b exp 11", {busy, in_ready}); end
    stream(8, 16'h0001, 1'b0, got, cyc);
    checks++; if (got !== 8 || cyc !== 8) begin errors++; $display("FAIL t1_throughput: got %0d words in %0d cycles exp 8 in 8", got, cyc); end
    checks++; if ({in_ready, d_we, busy} !== 3'b011) begin errors++; $display("FAIL t1_last_plus1: got rdy/we/busy %b exp 011", {in_ready, d_we, busy}); end
    checks++; if (d_addr !== 10'd0 || wdata !== mk_line(16'h0001, 8)) begin errors++; $display("FAIL t1_line: got %h @%0d exp %h @0", wdata, d_addr, mk_line(16'h0001, 8)); end
    tick();
    checks++; if ({done, busy} !== 2'b10) begin errors++; $display("FAIL t1_done: got done/busy %b exp 10", {done, busy}); end
    tick();
    checks++; if ({done, err} !== 2'b00) begin errors++; $display("FAIL t1_after: got done/err %b exp 00", {done, err}); end
    checks++; if (wr_ram.size() - n0 !== 1) begin errors++; $display("FAIL t1_nwrites: got %0d exp 1", wr_ram.size() - n0); end
  endtask

  task automatic test_partial_line();
    int n0 = wr_ram.size();
    int got, cyc;
    do_start(2'd1, 13'd8190, 16'd10);
    stream(10, 16'h0101, 1'b0, got, cyc);
    checks++; if (got !== 10 || cyc !== 10) begin errors++; $display("FAIL t2_throughput: got %0d words in %0d cycles exp 10 in 10", got, cyc); end
    tick(); tick(); tick();
    checks++; if (wr_ram.size() - n0 !== 2) begin errors++; $display("FAIL t2_nwrites: got %0d exp 2", wr_ram.size() - n0); end
    else begin
      checks++; if (wr_ram[n0] !== 2'd1 || wr_addr[n0] !== 13'd8190 || wr_dat[n0] !== mk_line(16'h0101, 8)) begin errors++; $display("FAIL t2_line0: got ram%0d @%0d %h exp ram1 @8190 %h", wr_ram[n0], wr_addr[n0], wr_dat[n0], mk_line(16'h0101, 8)); end
      checks++; if (wr_ram[n0+1] !== 2'd1 || wr_addr[n0+1] !== 13'd8191 || wr_dat[n0+1] !== mk_line(16'h0109, 2)) begin errors++; $display("FAIL t2_line1: got ram%0d @%0d %h exp ram1 @8191 %h", wr_ram[n0+1], wr_addr[n0+1], wr_dat[n0+1], mk_line(16'h0109, 2)); end
    end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL t2_err: got %b exp 0", err); end
  endtask

  task automatic test_gappy_stream();
    int n0 = wr_ram.size();
    int got, cyc;
    logic [12:0] ea [3] = '{13'd5, 13'd6, 13'd7};
    do_start(2'd2, 13'd5, 16'd20);
    stream(20, 16'h0200, 1'b1, got, cyc);
    checks++; if (got !== 20) begin errors++; $display("FAIL t3_accepted: got %0d exp 20", got); end
    tick(); tick(); tick();
    checks++; if (wr_ram.size() - n0 !== 3) begin errors++; $display("FAIL t3_nwrites: got %0d exp 3", wr_ram.size() - n0); end
    else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (wr_ram[n0+i] !== 2'd2 || wr_addr[n0+i] !== ea[i] || wr_dat[n0+i] !== mk_line(16'h0200 + 16'(8*i), (i == 2) ? 4 : 8)) begin
          errors++; $display("FAIL t3_line%0d: got ram%0d @%0d %h exp ram2 @%0d %h", i, wr_ram[n0+i], wr_addr[n0+i], wr_dat[n0+i], ea[i], mk_line(16'h0200 + 16'(8*i), (i == 2) ? 4 : 8));
        end
      end
    end
  endtask

  task automatic test_wrap();
    int n0 = wr_ram.size();
    int got, cyc;
    do_start(2'd0, 13'd1023, 16'd16);
    stream(16, 16'h0300, 1'b0, got, cyc);
    tick(); tick(); tick();
    checks++; if (wr_ram.size() - n0 !== 2) begin errors++; $display("FAIL t4_nwrites: got %0d exp 2", wr_ram.size() - n0); end
    else begin
      checks++; if (wr_ram[n0] !== 2'd0 || wr_addr[n0] !== 13'd1023 || wr_dat[n0] !== mk_line(16'h0300, 8)) begin errors++; $display("FAIL t4_line0: got ram%0d @%0d exp ram0 @1023", wr_ram[n0], wr_addr[n0]); end
      checks++; if (wr_ram[n0+1] !== 2'd0 || wr_addr[n0+1] !== 13'd0 || wr_dat[n0+1] !== mk_line(16'h0308, 8)) begin errors++; $display("FAIL t4_line1: got ram%0d @%0d exp ram0 @0", wr_ram[n0+1], wr_addr[n0+1]); end
    end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL t4_err: got %b exp 1", err); end
  endtask

  task automatic test_empty_and_invalid();
    int n0 = wr_ram.size();
    int d0 = done_cnt;
    do_start(2'd0, 13'd3, 16'd0);
    checks++; if ({busy, err, in_ready, done} !== 4'b1000) begin errors++; $display("FAIL t5_zero_s1: got busy/err/rdy/done %b exp 1000", {busy, err, in_ready, done}); end
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL t5_zero_done: got %b exp 1", done); end
    tick();
    do_start(2'd3, 13'd3, 16'd5);
    checks++; if ({busy, err} !== 2'b11) begin errors++; $display("FAIL t5_inv_s1: got busy/err %b exp 11", {busy, err}); end
    in_valid = 1'b1;
    tick();
    checks++; if ({done, err} !== 2'b11) begin errors++; $display("FAIL t5_inv_done: got done/err %b exp 11", {done, err}); end
    tick(); tick();
    in_valid = 1'b0;
    checks++; if (wr_ram.size() - n0 !== 0 || done_cnt - d0 !== 2) begin errors++; $display("FAIL t5_counts: got writes %0d dones %0d exp 0 2", wr_ram.size() - n0, done_cnt - d0); end
  endtask

  task automatic test_start_while_busy();
    int n0 = wr_ram.size();
    int d0 = done_cnt;
    int got, cyc;
    do_start(2'd1, 13'd100, 16'd12);
    stream(4, 16'h0400, 1'b0, got, cyc);
    start = 1'b1; sel = 2'd0; base_addr = 13'd0; word_count = 16'd0;
    stream(1, 16'h0404, 1'b0, got, cyc);
    start = 1'b0;
    stream(7, 16'h0405, 1'b0, got, cyc);
    tick(); tick(); tick();
    checks++; if (wr_ram.size() - n0 !== 2 || done_cnt - d0 !== 1) begin errors++; $display("FAIL t6_counts: got writes %0d dones %0d exp 2 1", wr_ram.size() - n0, done_cnt - d0); end
    else begin
      checks++; if (wr_ram[n0] !== 2'd1 || wr_addr[n0] !== 13'd100 || wr_dat[n0] !== mk_line(16'h0400, 8)) begin errors++; $display("FAIL t6_line0: got ram%0d @%0d %h exp ram1 @100", wr_ram[n0], wr_addr[n0], wr_dat[n0]); end
      checks++; if (wr_ram[n0+1] !== 2'd1 || wr_addr[n0+1] !== 13'd101 || wr_dat[n0+1] !== mk_line(16'h0408, 4)) begin errors++; $display("FAIL t6_line1: got ram%0d @%0d %h exp ram1 @101", wr_ram[n0+1], wr_addr[n0+1], wr_dat[n0+1]); end
    end
  endtask

  task automatic test_reset_mid_transfer();
    int n0 = wr_ram.size();
    int d0 = done_cnt;
    int got, cyc;
    do_start(2'd2, 13'd40, 16'd16);
    stream(5, 16'h0500, 1'b0, got, cyc);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if ({in_ready, busy, done, err, d_we, w_we, b_we} !== 7'd0) begin errors++; $display("FAIL t7_status: got %b exp 0000000", {in_ready, busy, done, err, d_we, w_we, b_we}); end
    checks++; if ({d_addr, w_addr, b_addr} !== 33'd0 || wdata !== 128'd0) begin errors++; $display("FAIL t7_addr_data: got %h/%h exp 0", {d_addr, w_addr, b_addr}, wdata); end
    in_valid = 1'b1; in_data = 32'h0000_0505;
    for (int i = 0; i < 12; i++) tick();
    in_valid = 1'b0;
    checks++; if (wr_ram.size() - n0 !== 0 || done_cnt - d0 !== 0 || in_ready !== 1'b0) begin errors++; $display("FAIL t7_quiet: got writes %0d dones %0d rdy %b exp 0 0 0", wr_ram.size() - n0, done_cnt - d0, in_ready); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sel = 2'd0; base_addr = 13'd0; word_count = 16'd0;
    in_valid = 1'b0; in_data = 32'd0;
    test_reset();
    test_full_line();
    test_partial_line();
    test_gappy_stream();
    test_wrap();
    test_empty_and_invalid();
    test_start_while_busy();
    test_reset_mid_transfer();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
